// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream boundary between two pipeline stages, with flush and occupancy.
// The stage register sits on the slave side; the upstream/downstream environment drives the master side.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_count;

    modport slave (
        input  i_flush, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_count
    );

    modport master (
        output i_flush, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: one main entry feeding o_data, plus an optional skid entry
// so that o_ready can come from a flop instead of the downstream i_ready.
module pipe_stage_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SKID        = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipe_stage_reg_if.slave    bus
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready;
    logic             push;
    logic             pop;

    // Ready is forced low during reset so nothing is accepted while the state is held clear.
    generate
        if (SKID != 0) begin : g_skid
            assign ready = i_rst_n & ~skid_vld_q;
        end else begin : g_noskid
            assign ready = i_rst_n & (~main_vld_q | bus.i_ready);
        end
    endgenerate

    assign push = bus.i_valid & ready;
    assign pop  = main_vld_q & bus.i_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (bus.i_flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = RESET_VALUE;
            skid_d     = RESET_VALUE;
        end else if (push && pop) begin
            main_d = bus.i_data;
        end else if (push) begin
            if ((SKID != 0) && main_vld_q) begin
                skid_d     = bus.i_data;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = bus.i_data;
                main_vld_d = 1'b1;
            end
        end else if (pop) begin
            // Drain keeps the last payload in main; only reset/flush reload RESET_VALUE.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= RESET_VALUE;
            skid_q     <= RESET_VALUE;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = main_vld_q;
    assign bus.o_data  = main_q;
    assign bus.o_count = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg with and without the skid entry.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV1 = 32'hDEAD_0000;
    localparam logic [31:0] RV0 = 32'h0000_00FF;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    pipe_stage_reg_if #(.WIDTH(32)) bus1 ();
    pipe_stage_reg_if #(.WIDTH(32)) bus0 ();

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV0), .SKID(0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int which, input logic v, input logic [31:0] d,
                          input logic r, input logic f);
        if (which == 1) begin
            bus1.i_valid = v; bus1.i_data = d; bus1.i_ready = r; bus1.i_flush = f;
        end else begin
            bus0.i_valid = v; bus0.i_data = d; bus0.i_ready = r; bus0.i_flush = f;
        end
    endtask

    task automatic get_out(input int which, output logic rdy, output logic vld,
                           output logic [31:0] dat, output logic [1:0] cnt);
        if (which == 1) begin
            rdy = bus1.o_ready; vld = bus1.o_valid; dat = bus1.o_data; cnt = bus1.o_count;
        end else begin
            rdy = bus0.o_ready; vld = bus0.o_valid; dat = bus0.o_data; cnt = bus0.o_count;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic vld, input logic [31:0] dat,
                        input logic [1:0] cnt, input logic rdy);
        check({tag, ".valid"}, {31'd0, bus1.o_valid}, {31'd0, vld});
        check({tag, ".data"},  bus1.o_data, dat);
        check({tag, ".count"}, {30'd0, bus1.o_count}, {30'd0, cnt});
        check({tag, ".ready"}, {31'd0, bus1.o_ready}, {31'd0, rdy});
    endtask

    task automatic run_random(input int which, input int cycles);
        logic [31:0] q[$];
        logic        v, r, f, exp_rdy, o_rdy, o_vld;
        logic [31:0] d, o_dat;
        logic [1:0]  o_cnt;
        logic        push, pop;
        for (int c = 0; c < cycles; c++) begin
            v = ($urandom_range(9) < 6);
            r = ($urandom_range(9) < 5);
            f = ($urandom_range(63) == 0);
            d = $urandom;
            set_in(which, v, d, r, f);
            #1;
            exp_rdy = (which == 1) ? (q.size() < 2) : ((q.size() == 0) || r);
            get_out(which, o_rdy, o_vld, o_dat, o_cnt);
            check("rand.ready", {31'd0, o_rdy}, {31'd0, exp_rdy});
            push = v && exp_rdy;
            pop  = (q.size() > 0) && r;
            @(posedge clk);
            #1;
            if (f) begin
                q.delete();
            end else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(d);
            end
            get_out(which, o_rdy, o_vld, o_dat, o_cnt);
            check("rand.valid", {31'd0, o_vld}, {31'd0, (q.size() > 0)});
            check("rand.count", {30'd0, o_cnt}, q.size());
            if (q.size() > 0) check("rand.data", o_dat, q[0]);
        end
        set_in(which, 1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        set_in(which, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        set_in(1, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(0, 1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk1("reset", 1'b0, RV1, 2'd0, 1'b0);
        check("reset0.data", bus0.o_data, RV0);
        check("reset0.ready", {31'd0, bus0.o_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk1("release", 1'b0, RV1, 2'd0, 1'b1);

        // Streaming with i_ready held high.
        for (int i = 1; i <= 8; i++) begin
            set_in(1, 1'b1, i, 1'b1, 1'b0);
            tick();
            chk1("stream", 1'b1, i, 2'd1, 1'b1);
        end
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk1("drain", 1'b0, 32'd8, 2'd0, 1'b1);

        // Backpressure into the skid entry.
        set_in(1, 1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        chk1("bp.a", 1'b1, 32'hA, 2'd1, 1'b1);
        set_in(1, 1'b1, 32'hB, 1'b0, 1'b0);
        tick();
        chk1("bp.b", 1'b1, 32'hA, 2'd2, 1'b0);
        set_in(1, 1'b1, 32'hC, 1'b0, 1'b0);
        tick();
        chk1("bp.c_blocked", 1'b1, 32'hA, 2'd2, 1'b0);
        set_in(1, 1'b1, 32'hC, 1'b1, 1'b0);
        tick();
        chk1("bp.pop_a", 1'b1, 32'hB, 2'd1, 1'b1);
        tick();
        chk1("bp.pop_b", 1'b1, 32'hC, 2'd1, 1'b1);
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk1("bp.pop_c", 1'b0, 32'hC, 2'd0, 1'b1);

        // Flush from the full state with a coinciding push.
        set_in(1, 1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        set_in(1, 1'b1, 32'h22, 1'b0, 1'b0);
        tick();
        chk1("flush.full", 1'b1, 32'h11, 2'd2, 1'b0);
        set_in(1, 1'b1, 32'h33, 1'b0, 1'b1);
        tick();
        chk1("flush", 1'b0, RV1, 2'd0, 1'b1);
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk1("flush.dropped", 1'b0, RV1, 2'd0, 1'b1);

        // Asynchronous reset mid-cycle from the full state.
        set_in(1, 1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        set_in(1, 1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        set_in(1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk1("areset.full", 1'b1, 32'h44, 2'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("areset", 1'b0, RV1, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk1("areset.release", 1'b0, RV1, 2'd0, 1'b1);

        // Single-entry variant.
        set_in(0, 1'b1, 32'h5, 1'b0, 1'b0);
        #1;
        check("s0.ready_empty", {31'd0, bus0.o_ready}, 32'd1);
        tick();
        check("s0.data5", bus0.o_data, 32'h5);
        check("s0.valid5", {31'd0, bus0.o_valid}, 32'd1);
        set_in(0, 1'b1, 32'h6, 1'b0, 1'b0);
        #1;
        check("s0.ready_stall", {31'd0, bus0.o_ready}, 32'd0);
        set_in(0, 1'b1, 32'h6, 1'b1, 1'b0);
        #1;
        check("s0.ready_comb", {31'd0, bus0.o_ready}, 32'd1);
        tick();
        check("s0.data6", bus0.o_data, 32'h6);
        check("s0.valid6", {31'd0, bus0.o_valid}, 32'd1);
        check("s0.count6", {30'd0, bus0.o_count}, 32'd1);
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        check("s0.drain_valid", {31'd0, bus0.o_valid}, 32'd0);
        check("s0.drain_data", bus0.o_data, 32'h6);
        set_in(0, 1'b1, 32'h7, 1'b0, 1'b0);
        tick();
        set_in(0, 1'b1, 32'h8, 1'b0, 1'b1);
        tick();
        check("s0.flush_valid", {31'd0, bus0.o_valid}, 32'd0);
        check("s0.flush_data", bus0.o_data, RV0);
        set_in(0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();

        run_random(1, 2000);
        run_random(0, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
